// File: rtl/vp_window_decim.sv
// Video window crop with power-of-two decimation; all outputs registered, one cycle of latency.
// Define VP_WINDOW_FILL_EN to pad each non-empty output line with FILL_DATA up to FILL_LEN pixels.
module vp_window_decim #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned X_W       = 12,
    parameter int unsigned Y_W       = 12,
    parameter int unsigned FILL_LEN  = 1280,
    parameter int unsigned FILL_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    start_x,
    input  logic [X_W-1:0]    end_x,
    input  logic [Y_W-1:0]    start_y,
    input  logic [Y_W-1:0]    end_y,
    input  logic [1:0]        decim_x,
    input  logic [1:0]        decim_y,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vs_o,
    output logic              de_o,
    output logic [DATA_W-1:0] data_o,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              fill_trunc
);
    localparam int unsigned CNT_W = $clog2(FILL_LEN + 1);

    if (FILL_LEN == 0 || (FILL_DATA >> DATA_W) != 0) begin : g_param_check
        $error("vp_window_decim: FILL_LEN must be nonzero and FILL_DATA must fit in DATA_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_LINE  = 2'd2
`ifdef VP_WINDOW_FILL_EN
        ,
        S_FILL  = 2'd3
`endif
    } state_t;

    state_t           state, state_nxt;
    logic             vs_d, de_d, seen_vs;
    logic [X_W-1:0]   x, sh_sx, sh_ex;
    logic [Y_W-1:0]   y, sh_sy, sh_ey;
    logic [1:0]       sh_dx, sh_dy;
    logic [CNT_W-1:0] out_cnt;

    logic              vs_rise_c, de_fall_c, keep_c, pad_c, de_c;
    logic [DATA_W-1:0] data_c;
    logic [X_W-1:0]    dx_c;
    logic [Y_W-1:0]    dy_c;
    logic [7:0]        xm8_c, ym8_c;
    logic [CNT_W-1:0]  line_cnt_c;

    assign vs_rise_c  = vs_i & ~vs_d;
    assign de_fall_c  = de_d & ~de_i;
    assign xm8_c      = (8'd1 << sh_dx) - 8'd1;
    assign ym8_c      = (8'd1 << sh_dy) - 8'd1;
    assign dx_c       = x - sh_sx;
    assign dy_c       = y - sh_sy;
    // Kept-pixel count of the line in progress; a new line starts from zero.
    assign line_cnt_c = (state == S_LINE) ? out_cnt : '0;

    assign keep_c = (state != S_IDLE) && !vs_rise_c && de_i && !cfg_err
                 && (x >= sh_sx) && (x < sh_ex) && (y >= sh_sy) && (y < sh_ey)
                 && ((dx_c & X_W'(xm8_c)) == '0) && ((dy_c & Y_W'(ym8_c)) == '0)
                 && (line_cnt_c < CNT_W'(FILL_LEN));

`ifdef VP_WINDOW_FILL_EN
    logic pad_last_c;
    // Padding starts on the de_i falling cycle and yields to any new input activity.
    assign pad_c = !vs_rise_c
                && ((((state == S_LINE) && de_fall_c && (out_cnt != '0)
                      && (out_cnt < CNT_W'(FILL_LEN))))
                    || ((state == S_FILL) && !de_i));
    assign pad_last_c = pad_c && (out_cnt == CNT_W'(FILL_LEN - 1));
`else
    assign pad_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (vs_rise_c) begin
            state_nxt = S_BLANK;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_BLANK: if (de_i) state_nxt = S_LINE;
                S_LINE: begin
                    if (de_fall_c) begin
                        state_nxt = S_BLANK;
`ifdef VP_WINDOW_FILL_EN
                        if (pad_c && !pad_last_c) state_nxt = S_FILL;
`endif
                    end
                end
`ifdef VP_WINDOW_FILL_EN
                S_FILL: begin
                    if (de_i)            state_nxt = S_LINE;
                    else if (pad_last_c) state_nxt = S_BLANK;
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output selection: kept input pixel, pad pixel, or blank
    always_comb begin
        de_c   = keep_c;
        data_c = keep_c ? data_i : '0;
`ifdef VP_WINDOW_FILL_EN
        if (pad_c) begin
            de_c   = 1'b1;
            data_c = DATA_W'(FILL_DATA);
        end
`endif
    end

    // Input edge history and per-frame configuration shadows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d    <= 1'b0;
            de_d    <= 1'b0;
            seen_vs <= 1'b0;
            sh_sx   <= '0;
            sh_ex   <= '0;
            sh_sy   <= '0;
            sh_ey   <= '0;
            sh_dx   <= '0;
            sh_dy   <= '0;
        end else begin
            vs_d <= vs_i;
            de_d <= de_i;
            if (vs_rise_c) begin
                seen_vs <= 1'b1;
                sh_sx   <= start_x;
                sh_ex   <= end_x;
                sh_sy   <= start_y;
                sh_ey   <= end_y;
                sh_dx   <= decim_x;
                sh_dy   <= decim_y;
            end
        end
    end

    // Saturating column/row counters and per-line output count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            out_cnt <= '0;
        end else begin
            if (vs_rise_c)      x <= '0;
            else if (de_i)      x <= (x == '1) ? x : x + X_W'(1);
            else if (de_fall_c) x <= '0;

            if (vs_rise_c)      y <= '0;
            else if (de_fall_c) y <= (y == '1) ? y : y + Y_W'(1);

            if (vs_rise_c)  out_cnt <= '0;
            else if (de_i)  out_cnt <= line_cnt_c + CNT_W'(keep_c);
            else if (pad_c) out_cnt <= out_cnt + CNT_W'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_o       <= 1'b0;
            de_o       <= 1'b0;
            data_o     <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            fill_trunc <= 1'b0;
        end else begin
            vs_o       <= vs_i;
            de_o       <= de_c;
            data_o     <= data_c;
            frame_done <= vs_rise_c & seen_vs;
            if (vs_rise_c) cfg_err <= (end_x <= start_x) || (end_y <= start_y);
`ifdef VP_WINDOW_FILL_EN
            if ((state == S_FILL) && (de_i || vs_rise_c)) fill_trunc <= 1'b1;
`else
            fill_trunc <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_vp_window_decim.sv
// Scoreboard bench for vp_window_decim: the driver queues expected pixels/events, a monitor pops and compares.
module tb_vp_window_decim;
`ifdef VP_WINDOW_FILL_EN
    localparam bit FILL = 1'b1;
    localparam int FL   = 6;
`else
    localparam bit FILL = 1'b0;
    localparam int FL   = 1280;
`endif
    localparam logic [15:0] PAD = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] start_x, end_x, start_y, end_y;
    logic [1:0]  decim_x, decim_y;
    logic        vs_i, de_i;
    logic [15:0] data_i;
    logic        vs_o, de_o;
    logic [15:0] data_o;
    logic        frame_done, cfg_err, fill_trunc;

    vp_window_decim #(
        .DATA_W(16), .X_W(12), .Y_W(12), .FILL_LEN(FL), .FILL_DATA(32'h5A5A)
    ) dut (
        .clk(clk), .rst(rst),
        .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
        .decim_x(decim_x), .decim_y(decim_y),
        .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
        .vs_o(vs_o), .de_o(de_o), .data_o(data_o),
        .frame_done(frame_done), .cfg_err(cfg_err), .fill_trunc(fill_trunc)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] stamp;
    } exp_t;

    exp_t       pix_q[$];
    int         vs_q[$];
    int         fd_q[$];
    int         checks;
    int         failures;
    logic [7:0] mask [4];
    bit         vs_seen;
    bit         exp_trunc;

    function automatic logic [15:0] pix(input int x, input int y);
        return 16'(32'hA000 + y * 16 + x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic extra(input string name);
        checks++;
        failures++;
        $display("FAIL %s: output asserted with nothing expected (data_o=%0h, cycle %0d)", name, data_o, cyc);
    endtask

    // Monitor: runs once per falling edge, away from the active edge
    task automatic mon_step();
        exp_t e;
        if (de_o) begin
            if (pix_q.size() == 0) extra("pix_extra");
            else begin
                e = pix_q.pop_front();
                chk("pix_data", 32'(data_o), 32'(e.data));
                chk("pix_cycle", cyc, e.stamp);
            end
        end else begin
            chk("idle_data", 32'(data_o), 32'd0);
        end
        if (vs_o) begin
            if (vs_q.size() == 0) extra("vs_extra");
            else chk("vs_cycle", cyc, vs_q.pop_front());
        end
        if (frame_done) begin
            if (fd_q.size() == 0) extra("frame_done_extra");
            else chk("frame_done_cycle", cyc, fd_q.pop_front());
        end
    endtask

    task automatic tick(input logic v, input logic d, input logic [15:0] dat, output int st);
        @(negedge clk);
        vs_i   = v;
        de_i   = d;
        data_i = dat;
        st     = cyc + 1;
    endtask

    task automatic cfg(input int sx, input int ex, input int sy, input int ey,
                       input int dx, input int dy);
        start_x = 12'(sx);
        end_x   = 12'(ex);
        start_y = 12'(sy);
        end_y   = 12'(ey);
        decim_x = 2'(dx);
        decim_y = 2'(dy);
    endtask

    task automatic vs_pulse();
        int st;
        tick(1'b1, 1'b0, 16'h0, st);
        vs_q.push_back(st);
        if (vs_seen) fd_q.push_back(st);
        vs_seen = 1'b1;
    endtask

    // One frame: vs pulse, two blank cycles, h lines of w pixels each followed by hb blank cycles
    task automatic send_frame(input int w, input int h, input int hb, input int new_sx);
        int   st;
        int   k;
        int   trail;
        exp_t e;
        vs_pulse();
        repeat (2) tick(1'b0, 1'b0, 16'h0, st);
        for (int yy = 0; yy < h; yy++) begin
            k = 0;
            for (int xx = 0; xx < w; xx++) begin
                tick(1'b0, 1'b1, pix(xx, yy), st);
                if (mask[yy][xx] && k < FL) begin
                    e.data  = pix(xx, yy);
                    e.stamp = 32'(st);
                    pix_q.push_back(e);
                    k++;
                end
            end
            if (new_sx >= 0 && yy == 0) start_x = 12'(new_sx);
            trail = (yy == h - 1) ? hb + 8 : hb;
            for (int j = 0; j < trail; j++) begin
                tick(1'b0, 1'b0, 16'h0, st);
                if (FILL && k > 0 && k + j < FL) begin
                    e.data  = PAD;
                    e.stamp = 32'(st);
                    pix_q.push_back(e);
                end
            end
            if (FILL && k > 0 && k + trail < FL) exp_trunc = 1'b1;
        end
    endtask

    initial begin
        int   st;
        int   hb;
        exp_t e;
        rst = 1'b1; vs_i = 1'b0; de_i = 1'b0; data_i = 16'h0;
        cfg(0, 0, 0, 0, 0, 0);
        checks = 0; failures = 0; vs_seen = 1'b0; exp_trunc = 1'b0;
        mask = '{8'h00, 8'h00, 8'h00, 8'h00};
        hb = FILL ? 6 : 2;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_de_o", 32'(de_o), 32'd0);
        chk("rst_vs_o", 32'(vs_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_fill_trunc", 32'(fill_trunc), 32'd0);
        rst = 1'b0;

        // Video before the first vs: stays idle
        cfg(0, 8, 0, 4, 0, 0);
        for (int xx = 0; xx < 8; xx++) tick(1'b0, 1'b1, pix(xx, 0), st);
        repeat (3) tick(1'b0, 1'b0, 16'h0, st);

        // Full window, no decimation
        mask = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(8, 4, hb, -1);
        chk("cfg_err_ok1", 32'(cfg_err), 32'd0);

        // Window (2,1)-(6,3), decim_x=1; start_x moved mid-frame must not apply yet
        cfg(2, 6, 1, 3, 1, 0);
        mask = '{8'h00, 8'h14, 8'h14, 8'h00};
        send_frame(8, 4, hb, 3);
        mask = '{8'h00, 8'h28, 8'h28, 8'h00};
        send_frame(8, 4, hb, -1);

        // Empty window
        cfg(3, 3, 0, 4, 0, 0);
        mask = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(8, 4, hb, -1);
        chk("cfg_err_empty", 32'(cfg_err), 32'd1);

        // decim 4x2 over full frame
        cfg(0, 8, 0, 4, 2, 1);
        mask = '{8'h11, 8'h00, 8'h11, 8'h00};
        send_frame(8, 4, hb, -1);
        chk("cfg_err_ok2", 32'(cfg_err), 32'd0);

        // decim_x=3 on a single-row window starting at column 1
        cfg(1, 8, 0, 1, 3, 0);
        mask = '{8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(8, 4, hb, -1);

`ifdef VP_WINDOW_FILL_EN
        cfg(0, 4, 0, 2, 0, 0);
        mask = '{8'h0F, 8'h0F, 8'h00, 8'h00};
        send_frame(4, 2, 5, -1);
        chk("fill_trunc_clean", 32'(fill_trunc), 32'(exp_trunc));
        send_frame(4, 2, 1, -1);
        chk("fill_trunc_cut", 32'(fill_trunc), 32'd1);
`endif

        // Reset in the middle of a line at x=3
        cfg(0, 8, 0, 4, 0, 0);
        mask = '{8'h00, 8'h00, 8'h00, 8'h00};
        vs_pulse();
        repeat (2) tick(1'b0, 1'b0, 16'h0, st);
        for (int xx = 0; xx < 4; xx++) begin
            tick(1'b0, 1'b1, pix(xx, 0), st);
            if (xx < 3) begin
                e.data  = pix(xx, 0);
                e.stamp = 32'(st);
                pix_q.push_back(e);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_de_o", 32'(de_o), 32'd0);
        chk("midrst_data_o", 32'(data_o), 32'd0);
        chk("midrst_vs_o", 32'(vs_o), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
        chk("midrst_fill_trunc", 32'(fill_trunc), 32'd0);
        vs_seen   = 1'b0;
        exp_trunc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int xx = 4; xx < 8; xx++) tick(1'b0, 1'b1, pix(xx, 0), st);
        repeat (3) tick(1'b0, 1'b0, 16'h0, st);
        for (int xx = 0; xx < 8; xx++) tick(1'b0, 1'b1, pix(xx, 1), st);
        repeat (3) tick(1'b0, 1'b0, 16'h0, st);

        // Output resumes after the next vs; no frame_done for the first vs after reset
        cfg(2, 6, 1, 3, 1, 0);
        mask = '{8'h00, 8'h14, 8'h14, 8'h00};
        send_frame(8, 4, hb, -1);

        repeat (10) tick(1'b0, 1'b0, 16'h0, st);
        chk("pix_pending", 32'(pix_q.size()), 32'd0);
        chk("vs_pending", 32'(vs_q.size()), 32'd0);
        chk("frame_done_pending", 32'(fd_q.size()), 32'd0);
        chk("fill_trunc_end", 32'(fill_trunc), 32'(exp_trunc));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
